// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// Synchronises the asynchronous rxd line, validates the start bit at its
// centre, samples eight data bits LSB-first at bit centres and checks the
// stop bit. A good byte is published on data_out with a one-cycle rx_done;
// a low stop bit produces a one-cycle frame_err and leaves data_out alone.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rxd        serial line, idles high, asynchronous to clk
//   data_out   last correctly received byte
//   rx_done    one-cycle strobe, data_out updated this cycle
//   frame_err  one-cycle strobe, stop bit sampled low
//   rx_busy    high while a frame is in progress
//
// state | meaning
// IDLE  | line idle, waiting for rxd_s low
// START | timing to start-bit centre, rejects glitches
// DATA  | sampling 8 data bits at bit centres
// STOP  | sampling stop bit, issues rx_done or frame_err

module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          rxd_m, rxd_s;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    sh, sh_nxt;
    logic [7:0]    data_nxt;
    logic          done_nxt, err_nxt;

    // Two-flop synchroniser; resets to the idle level so reset release
    // never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data_out  <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            sh        <= sh_nxt;
            data_out  <= data_nxt;
            rx_done   <= done_nxt;
            frame_err <= err_nxt;
            rx_busy   <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        data_nxt  = data_out;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!rxd_s) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    // Line back high at the start-bit centre: a glitch.
                    state_nxt = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    sh_nxt[idx] = rxd_s;
                    cnt_nxt     = '0;
                    idx_nxt     = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            STOP: begin
                // Leaving at the stop-bit centre leaves half a bit of margin
                // to catch a start bit that follows with no idle time.
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rxd_s) begin
                        data_nxt = sh;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path, the counterpart of `uart_tx`: it consumes the `txd` line of a transmitter (or an external pin) and reassembles 8N1 frames into bytes. It synchronises the asynchronous line, validates the start bit at mid-bit, samples 8 data bits LSB-first at bit centres, and checks the stop bit. Each good byte is presented on `data_out` with a single-cycle `rx_done` strobe. Framing errors are flagged with a single-cycle `frame_err` strobe.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud). Must equal the `uart_tx` setting. Legal range is ≥ 4.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `rxd`  input  1  serial line; asynchronous to `clk`; idles high.
- `data_out`  output  8  last correctly received byte.
- `rx_done`  output  1  one-cycle strobe: `data_out` was updated this cycle.
- `frame_err`  output  1  one-cycle strobe: stop bit sampled low.
- `rx_busy`  output  1  high while a frame is in progress (any state other than IDLE).

## Operation
- **Synchroniser.** `rxd` passes through 2 flops, `rxd_s`. Both flops reset to 1. All decisions use `rxd_s` only.
- **Counters.**
  - Bit-time counter `cnt`: width `$clog2(CLKS_PER_BIT)`.
  - Bit index `idx`: 3 bits.
  - Shift register `sh`: 8 bits.
- **IDLE**
  - `cnt` = 0 and `idx` = 0.
  - If `rxd_s` == 0, go to START.
- **START**
  - `cnt` increments every cycle.
  - At `cnt` == (CLKS_PER_BIT-1)/2 (integer division), sample `rxd_s`:
    - 0: clear `cnt` and go to DATA.
    - 1: treat as a glitch and return to IDLE. No strobe is generated.
- **DATA**
  - `cnt` increments every cycle.
  - At `cnt` == CLKS_PER_BIT-1: `sh[idx]` ← `rxd_s`, clear `cnt`, increment `idx`.
  - After the sample with `idx` == 7, go to STOP with `idx` wrapped to 0.
- **STOP**
  - At `cnt` == CLKS_PER_BIT-1, sample `rxd_s`:
    - 1: `data_out` ← `sh` and `rx_done` = 1 for that cycle.
    - 0: `frame_err` = 1 for that cycle; `data_out` is unchanged.
  - In both cases, go to IDLE on the next cycle.
- **Back-to-back frames.** Because STOP exits at the stop-bit centre, a start bit that immediately follows a stop bit is detected without loss.
- **Simultaneous strobes.** `rx_done` and `frame_err` are never high in the same cycle.
- **Reset mid-frame.**
  - Abandon the frame immediately and go to IDLE.
  - Clear `cnt`, `idx` and `sh`.
  - No strobes are generated.
  - The frame in flight is lost. The receiver resynchronises on the next falling edge seen in IDLE. Continuous low after reset (line break) produces a frame of 0x00 followed by `frame_err`, then restarts.
- **Unencoded states** recover to IDLE.

## Timing
- **Reset values:** `data_out` = 8'h00, `rx_done` = 0, `frame_err` = 0, `rx_busy` = 0, state = IDLE.
- **Outputs** are registered; no combinational path from `rxd` to any output.
- **Start detection:** a falling edge on `rxd` reaches `rxd_s` after 2 clocks. START is entered on the following edge.
- **`rx_done` latency:** 2 (sync) + 1 + (CLKS_PER_BIT-1)/2 + 9·CLKS_PER_BIT cycles (±1) after the `rxd` falling edge, i.e. ~9.5 bit times. `frame_err` has the same latency.
- **Sample points:** each data bit is sampled at the centre of its bit time, with tolerance of ±(CLKS_PER_BIT/2 − 3) cycles of accumulated drift per frame.
- **Glitch rejection:** a low pulse shorter than (CLKS_PER_BIT-1)/2 cycles on `rxd` produces no output.
- **Strobe width:** `rx_done` and `frame_err` are exactly 1 cycle wide.
- **`data_out` hold:** `data_out` holds its value until the next `rx_done`.
- **`rx_busy`:** rises the cycle START is entered and falls the cycle IDLE is re-entered.

## Test plan
- **Single frame**
  - Stimulus: CLKS_PER_BIT=16, 20 ns clock, `rst` low for 20 ns, then drive 8N1 frame 0xAA on `rxd`.
  - Required response: exactly one `rx_done` pulse, with `data_out` = 8'hAA in that cycle and after it. `frame_err` never asserts.
- **Loopback**
  - Stimulus: instantiate `uart_tx` (same CLKS_PER_BIT) driving `rxd`; send 0x55, 0x00, 0xFF, 0xA5.
  - Required response: four `rx_done` pulses with matching `data_out`. Each `rx_done` appears within ±2 cycles of the corresponding `tx_done` at the transmitter.
- **False start**
  - Stimulus: CLKS_PER_BIT=16; a 5-cycle low pulse on an idle `rxd`.
  - Required response: `rx_busy` pulses; no `rx_done` and no `frame_err`; `data_out` is unchanged. A following frame 0x3C is received correctly.
- **Framing error**
  - Stimulus: frame 0x81 with the stop bit driven low.
  - Required response: a one-cycle `frame_err` and no `rx_done`; `data_out` keeps its previous value. A subsequent valid 0x81 yields `rx_done` with `data_out` = 8'h81.
- **Reset mid-frame**
  - Stimulus: assert `rst` low during data bit 4 of 0xF0, then release.
  - Required response: all outputs return to reset values asynchronously, with no strobe from the aborted frame. The next complete frame 0x0F is received as 8'h0F.
- **Back-to-back frames**
  - Stimulus: frames 0x12 and 0x34 with zero idle between stop and start.
  - Required response: two `rx_done` strobes 10·CLKS_PER_BIT (±1) cycles apart, carrying 8'h12 then 8'h34.
